// File: rtl/rom_dl_pkg.sv
// Shared types and helpers for the ROM download router: FSM states,
// error-flag bit positions and the per-region address decode.
package rom_dl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    ISSUE,
    FLUSH,
    DONE
  } dl_state_t;

  localparam int ERR_OOR = 0;
  localparam int ERR_OVR = 1;

  // Wide enough for the largest region index (NREG <= 8)
  localparam int RIDX_W = 3;

  // Operands are zero-extended by the caller, so base + size cannot wrap here
  function automatic logic in_region(input logic [63:0] addr,
                                     input logic [63:0] base,
                                     input logic [63:0] size);
    return (addr >= base) && (addr < (base + size));
  endfunction

endpackage

// File: rtl/rom_dl_pack.sv
// Byte-to-word packer: holds one pending byte and forms either a completed
// word (pending low + incoming high) or a zero-padded flush word.
module rom_dl_pack
  import rom_dl_pkg::*;
#(
  parameter int RAW = 14,
  parameter int DW  = 8
) (
  input  logic              clk_sys,
  input  logic              RESET_n,
  input  logic              clr,
  input  logic              load,
  input  logic              consume,
  input  logic [7:0]        in_byte,
  input  logic [RIDX_W-1:0] in_region,
  input  logic [RAW-1:0]    in_word,
  input  logic              in_odd,
  output logic              pend_valid,
  output logic [RIDX_W-1:0] pend_region,
  output logic [RAW-1:0]    pend_word,
  output logic              pend_match,
  output logic [DW-1:0]     merge_data,
  output logic [DW-1:0]     flush_data
);

  logic              valid_reg;
  logic [7:0]        byte_reg;
  logic [RIDX_W-1:0] region_reg;
  logic [RAW-1:0]    word_reg;
  logic              odd_reg;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      valid_reg  <= 1'b0;
      byte_reg   <= '0;
      region_reg <= '0;
      word_reg   <= '0;
      odd_reg    <= 1'b0;
    end else if (clr) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      valid_reg  <= 1'b1;
      byte_reg   <= in_byte;
      region_reg <= in_region;
      word_reg   <= in_word;
      odd_reg    <= in_odd;
    end else if (consume) begin
      valid_reg <= 1'b0;
    end
  end

  assign pend_valid  = valid_reg;
  assign pend_region = region_reg;
  assign pend_word   = word_reg;

  // Only a held even byte followed by the odd byte of the same word completes it
  assign pend_match = valid_reg && !odd_reg && in_odd &&
                      (region_reg == in_region) && (word_reg == in_word);

  generate
    if (DW == 16) begin : g_dw16
      assign merge_data = {in_byte, byte_reg};
      assign flush_data = {8'h00, byte_reg};
    end else begin : g_dw8
      assign merge_data = DW'(in_byte);
      assign flush_data = DW'(byte_reg);
    end
  endgenerate

endmodule

// File: rtl/rom_dl_router.sv
// Routes host ioctl download bytes into up to eight ROM regions, with
// region decode, optional 16-bit packing and a ready/valid write handshake.
module rom_dl_router
  import rom_dl_pkg::*;
#(
  parameter int NREG     = 4,
  parameter int AW       = 25,
  parameter int RAW      = 14,
  parameter int DW       = 8,
  parameter int DL_INDEX = 0,
  parameter logic [NREG*AW-1:0] REGION_BASE = {25'h3000, 25'h2000, 25'h1000, 25'h0000},
  parameter logic [NREG*AW-1:0] REGION_SIZE = {25'h1000, 25'h1000, 25'h1000, 25'h1000}
) (
  input  logic            clk_sys,
  input  logic            RESET_n,
  input  logic            ioctl_download,
  input  logic [7:0]      ioctl_index,
  input  logic            ioctl_wr,
  input  logic [AW-1:0]   ioctl_addr,
  input  logic [7:0]      ioctl_dout,
  output logic            ioctl_wait,
  input  logic            dn_ready,
  output logic [NREG-1:0] dn_wr,
  output logic [RAW-1:0]  dn_addr,
  output logic [DW-1:0]   dn_data,
  output logic            dl_active,
  output logic            dl_done,
  output logic [1:0]      err_flags
);

  localparam int SH = (DW == 16) ? 1 : 0;

  generate
    if (NREG < 1 || NREG > 8) begin : g_bad_nreg
      $error("rom_dl_router: NREG must be 1..8");
    end
    if (DW != 8 && DW != 16) begin : g_bad_dw
      $error("rom_dl_router: DW must be 8 or 16");
    end
  endgenerate

  logic [AW-1:0] base_arr [NREG];
  logic [AW-1:0] size_arr [NREG];

  generate
    for (genvar gi = 0; gi < NREG; gi++) begin : g_region
      localparam logic [AW:0] REG_END = {1'b0, REGION_BASE[gi*AW +: AW]} +
                                        {1'b0, REGION_SIZE[gi*AW +: AW]};
      assign base_arr[gi] = REGION_BASE[gi*AW +: AW];
      assign size_arr[gi] = REGION_SIZE[gi*AW +: AW];
      // A region may end exactly at 2**AW, but not beyond it
      if (REG_END[AW] && (REG_END[AW-1:0] != '0)) begin : g_overflow
        $error("rom_dl_router: region %0d end address overflows AW bits", gi);
      end
    end
  endgenerate

  // Region decode; walking downwards lets the lowest matching index win
  logic              hit;
  logic [RIDX_W-1:0] hit_idx;
  logic [AW-1:0]     hit_off;
  logic [RAW-1:0]    hit_word;
  logic [NREG-1:0]   hit_sel;

  always_comb begin
    hit     = 1'b0;
    hit_idx = '0;
    hit_off = '0;
    for (int i = NREG - 1; i >= 0; i--) begin
      if (in_region(64'(ioctl_addr), 64'(base_arr[i]), 64'(size_arr[i]))) begin
        hit     = 1'b1;
        hit_idx = RIDX_W'(i);
        hit_off = ioctl_addr - base_arr[i];
      end
    end
  end

  assign hit_word = RAW'(hit_off >> SH);
  assign hit_sel  = NREG'(1) << hit_idx;

  logic              pack_clr;
  logic              pack_load;
  logic              pack_consume;
  logic              pend_valid;
  logic [RIDX_W-1:0] pend_region;
  logic [RAW-1:0]    pend_word;
  logic              pend_match;
  logic [DW-1:0]     merge_data;
  logic [DW-1:0]     flush_data;
  logic [NREG-1:0]   pend_sel;

  rom_dl_pack #(
    .RAW (RAW),
    .DW  (DW)
  ) u_pack (
    .clk_sys     (clk_sys),
    .RESET_n     (RESET_n),
    .clr         (pack_clr),
    .load        (pack_load),
    .consume     (pack_consume),
    .in_byte     (ioctl_dout),
    .in_region   (hit_idx),
    .in_word     (hit_word),
    .in_odd      (hit_off[0]),
    .pend_valid  (pend_valid),
    .pend_region (pend_region),
    .pend_word   (pend_word),
    .pend_match  (pend_match),
    .merge_data  (merge_data),
    .flush_data  (flush_data)
  );

  assign pend_sel = NREG'(1) << pend_region;

  dl_state_t       state_reg, state_next;
  logic [NREG-1:0] sel_reg, sel_next;
  logic [RAW-1:0]  addr_reg, addr_next;
  logic [DW-1:0]   data_reg, data_next;
  logic [1:0]      err_reg, err_next;

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) begin
      sel_reg  <= '0;
      addr_reg <= '0;
      data_reg <= '0;
      err_reg  <= '0;
    end else begin
      sel_reg  <= sel_next;
      addr_reg <= addr_next;
      data_reg <= data_next;
      err_reg  <= err_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    sel_next     = sel_reg;
    addr_next    = addr_reg;
    data_next    = data_reg;
    err_next     = err_reg;
    pack_clr     = 1'b0;
    pack_load    = 1'b0;
    pack_consume = 1'b0;
    dn_wr        = '0;
    ioctl_wait   = 1'b0;
    dl_active    = (state_reg != IDLE);
    dl_done      = 1'b0;

    unique case (state_reg)
      IDLE: begin
        if (ioctl_download && (ioctl_index == 8'(DL_INDEX))) begin
          state_next = COLLECT;
          err_next   = '0;
          pack_clr   = 1'b1;
        end
      end

      COLLECT: begin
        if (!ioctl_download) begin
          if (pend_valid) begin
            sel_next     = pend_sel;
            addr_next    = pend_word;
            data_next    = flush_data;
            pack_consume = 1'b1;
            state_next   = FLUSH;
          end else begin
            state_next = DONE;
          end
        end else if (ioctl_wr) begin
          if (!hit) begin
            err_next[ERR_OOR] = 1'b1;
          end else if (DW == 8) begin
            sel_next   = hit_sel;
            addr_next  = hit_word;
            data_next  = merge_data;
            state_next = ISSUE;
          end else if (pend_match) begin
            sel_next     = hit_sel;
            addr_next    = hit_word;
            data_next    = merge_data;
            pack_consume = 1'b1;
            state_next   = ISSUE;
          end else if (pend_valid) begin
            // Old byte goes out zero-padded; the new byte takes its place
            sel_next   = pend_sel;
            addr_next  = pend_word;
            data_next  = flush_data;
            pack_load  = 1'b1;
            state_next = FLUSH;
          end else begin
            pack_load = 1'b1;
          end
        end
      end

      ISSUE, FLUSH: begin
        dn_wr      = sel_reg;
        ioctl_wait = 1'b1;
        if (ioctl_wr) begin
          err_next[ERR_OVR] = 1'b1;
        end
        // Returning to COLLECT lets a falling ioctl_download be handled there
        if (dn_ready) begin
          state_next = COLLECT;
        end
      end

      DONE: begin
        dl_done    = 1'b1;
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dn_addr   = addr_reg;
  assign dn_data   = data_reg;
  assign err_flags = err_reg;

endmodule
